// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: MMIO address map and control-register bit positions for uart_mmio_ctrl.
package uart_mmio_pkg;

  localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
  localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;

  // Control-register store bits
  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_FLUSH_RX = 1;

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush. Full/empty come from the
// registered count, so a push into a full FIFO is dropped even when a pop
// happens in the same cycle, and a pop of an empty FIFO is ignored.
// DEPTH=1 collapses to a single holding register.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Flush discards everything, including a same-cycle push.
  assign w_push_ok = i_push && !o_full  && !i_flush;
  assign w_pop_ok  = i_pop  && !o_empty && !i_flush;

  // Occupancy count; flush empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_count <= '0;
    else if (i_flush) r_count <= '0;
    else              r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
  end

  if (DEPTH == 1) begin : g_hold
    logic [WIDTH-1:0] r_hold;

    // Holding register, written only on an accepted push.
    always_ff @(posedge clk) begin
      if (w_push_ok) r_hold <= i_din;
    end

    assign o_head = o_empty ? '0 : r_hold;
  end else begin : g_ring
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Read/write pointers; power-of-two depth lets them wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO front end for the UART. Buffers CPU TX bytes in a FIFO
// drained over valid/ready, captures RX bytes for CPU loads, and tracks
// dropped RX bytes in a sticky overflow flag.
// Build option: define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO;
// otherwise the RX buffer is a single holding register.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        mmio_we,
  input  logic        mmio_re,
  input  logic [31:0] wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        trmt_full,
  output logic        recv_empty,
  output logic [7:0]  recv_data,
  output logic        rx_overflow
);

`ifdef UART_RX_FIFO_EN
  localparam int RX_BUF_DEPTH = RX_DEPTH;
`else
  // Single holding register; RX_DEPTH has no effect in this build.
  localparam int RX_BUF_DEPTH = (RX_DEPTH > 0) ? 1 : 1;
`endif

  logic w_tx_wr;
  logic w_rx_rd;
  logic w_ctrl_wr;
  logic w_rx_flush;
  logic w_ovf_clr;
  logic w_tx_empty;
  logic w_rx_full;
  logic w_rx_drop;
  logic r_rx_overflow;
  logic w_unused_wdata;

  // Full 32-bit address decode
  assign w_tx_wr    = mmio_we && (addr == UART_TX_ADDR);
  assign w_rx_rd    = mmio_re && (addr == UART_RX_ADDR);
  assign w_ctrl_wr  = mmio_we && (addr == UART_CTRL_ADDR);
  assign w_rx_flush = w_ctrl_wr && wdata[CTRL_FLUSH_RX];
  assign w_ovf_clr  = w_ctrl_wr && wdata[CTRL_CLR_OVF];
  // A byte arriving while the RX buffer is full at the start of the cycle is lost.
  assign w_rx_drop  = rx_valid && w_rx_full;

  assign w_unused_wdata = ^wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_wr),
    .i_din   (wdata[7:0]),
    .i_pop   (tx_ready),
    .i_flush (1'b0),
    .o_full  (trmt_full),
    .o_empty (w_tx_empty),
    .o_head  (tx_data)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_BUF_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (rx_valid),
    .i_din   (rx_data),
    .i_pop   (w_rx_rd),
    .i_flush (w_rx_flush),
    .o_full  (w_rx_full),
    .o_empty (recv_empty),
    .o_head  (recv_data)
  );

  assign tx_valid = !w_tx_empty;

  // Sticky overflow flag; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rx_overflow <= 1'b0;
    else if (w_rx_drop) r_rx_overflow <= 1'b1;
    else if (w_ovf_clr) r_rx_overflow <= 1'b0;
  end

  assign rx_overflow = r_rx_overflow;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: directed bench for uart_mmio_ctrl. Works in either build;
// RX expectations follow the buffer depth selected by UART_RX_FIFO_EN.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] A_CTRL = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
`ifdef UART_RX_FIFO_EN
  localparam int RXD = 8;
`else
  localparam int RXD = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        mmio_we;
  logic        mmio_re;
  logic [31:0] wdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        trmt_full;
  logic        recv_empty;
  logic [7:0]  recv_data;
  logic        rx_overflow;

  int checks   = 0;
  int failures = 0;

  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .mmio_we     (mmio_we),
    .mmio_re     (mmio_re),
    .wdata       (wdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .trmt_full   (trmt_full),
    .recv_empty  (recv_empty),
    .recv_data   (recv_data),
    .rx_overflow (rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mmio_we = 1'b1;
    tick();
    mmio_we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd(input logic [7:0] exp, input string tag);
    addr = A_RX; mmio_re = 1'b1;
    #1;
    chk(tag, {24'h0, recv_data}, {24'h0, exp});
    tick();
    mmio_re = 1'b0; addr = '0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = '0;
  endtask

  initial begin
    rst_n = 1'b1; addr = '0; mmio_we = 1'b0; mmio_re = 1'b0; wdata = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_tx_valid",   {31'h0, tx_valid},    32'h0);
    chk("rst_trmt_full",  {31'h0, trmt_full},   32'h0);
    chk("rst_recv_empty", {31'h0, recv_empty},  32'h1);
    chk("rst_recv_data",  {24'h0, recv_data},   32'h0);
    chk("rst_tx_data",    {24'h0, tx_data},     32'h0);
    chk("rst_overflow",   {31'h0, rx_overflow}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single TX byte with ready high
    tx_ready = 1'b1;
    wr(A_TX, 32'h41);
    chk("tx1_valid", {31'h0, tx_valid}, 32'h1);
    chk("tx1_data",  {24'h0, tx_data},  32'h41);
    tick();
    chk("tx1_gone",  {31'h0, tx_valid}, 32'h0);

    // Other addresses ignored (including upper-bit aliases)
    tx_ready = 1'b0;
    wr(32'h8000_000C, 32'h99);
    wr(32'h0000_0008, 32'h99);
    chk("bad_addr_tx", {31'h0, tx_valid}, 32'h0);

    // Fill TX, ninth byte dropped, then drain in order
    for (int i = 0; i < 8; i++) wr(A_TX, i);
    chk("tx_full8", {31'h0, trmt_full}, 32'h1);
    wr(A_TX, 32'h08);
    chk("tx_full9", {31'h0, trmt_full}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_drain_valid", {31'h0, tx_valid}, 32'h1);
      chk("tx_drain_data",  {24'h0, tx_data},  i);
      tick();
    end
    chk("tx_drain_end", {31'h0, tx_valid}, 32'h0);

    // RX bytes read back in order, then empty read returns zero
    rx(8'h55);
    chk("rx_not_empty", {31'h0, recv_empty}, 32'h0);
    rd(8'h55, "rx_rd_55");
    rx(8'hAA);
    rd(8'hAA, "rx_rd_AA");
    rd(8'h00, "rx_rd_empty");
    chk("rx_empty_after", {31'h0, recv_empty},  32'h1);
    chk("rx_no_ovf",      {31'h0, rx_overflow}, 32'h0);

    // Overflow: one byte more than the buffer holds
    for (int i = 0; i <= RXD; i++) rx(8'h10 + i[7:0]);
    chk("ovf_set",  {31'h0, rx_overflow}, 32'h1);
    chk("ovf_head", {24'h0, recv_data},   32'h10);
    wr(A_CTRL, 32'h1);
    chk("ovf_clr",       {31'h0, rx_overflow}, 32'h0);
    chk("ovf_clr_keep",  {24'h0, recv_data},   32'h10);
    for (int i = 0; i < RXD; i++) rd(8'h10 + i[7:0], "ovf_retained");
    chk("ovf_drained", {31'h0, recv_empty}, 32'h1);

    // Flush
    rx(8'h77);
    chk("flush_pre", {31'h0, recv_empty}, 32'h0);
    wr(A_CTRL, 32'h2);
    chk("flush_empty", {31'h0, recv_empty}, 32'h1);
    chk("flush_data",  {24'h0, recv_data},  32'h0);

    // Overflow clear and set in the same cycle: set wins
    for (int i = 0; i < RXD; i++) rx(8'h40 + i[7:0]);
    chk("full_no_ovf", {31'h0, rx_overflow}, 32'h0);
    addr = A_CTRL; wdata = 32'h1; mmio_we = 1'b1; rx_data = 8'hBB; rx_valid = 1'b1;
    tick();
    mmio_we = 1'b0; rx_valid = 1'b0; addr = '0; wdata = '0;
    chk("clr_set_wins", {31'h0, rx_overflow}, 32'h1);

    // Flush and rx_valid in the same cycle: flush wins
    addr = A_CTRL; wdata = 32'h2; mmio_we = 1'b1; rx_data = 8'hCC; rx_valid = 1'b1;
    tick();
    mmio_we = 1'b0; rx_valid = 1'b0; addr = '0; wdata = '0;
    chk("flush_wins", {31'h0, recv_empty}, 32'h1);
    wr(A_CTRL, 32'h1);
    chk("ovf_clr2", {31'h0, rx_overflow}, 32'h0);

    // RX full with simultaneous pop and rx_valid: byte dropped
    for (int i = 0; i < RXD; i++) rx(8'h20 + i[7:0]);
    chk("full2_no_ovf", {31'h0, rx_overflow}, 32'h0);
    addr = A_RX; mmio_re = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
    #1;
    chk("fullpop_head", {24'h0, recv_data}, 32'h20);
    tick();
    mmio_re = 1'b0; rx_valid = 1'b0; addr = '0;
    chk("fullpop_ovf",   {31'h0, rx_overflow}, 32'h1);
    chk("fullpop_empty", {31'h0, recv_empty},  (RXD == 1) ? 32'h1 : 32'h0);
    for (int i = 1; i < RXD; i++) rd(8'h20 + i[7:0], "fullpop_rest");
    chk("fullpop_dropped", {31'h0, recv_empty}, 32'h1);
    wr(A_CTRL, 32'h1);

    // Empty with simultaneous push and pop: push wins
    addr = A_RX; mmio_re = 1'b1; rx_data = 8'h5A; rx_valid = 1'b1;
    tick();
    mmio_re = 1'b0; rx_valid = 1'b0; addr = '0;
    chk("emptypp_not_empty", {31'h0, recv_empty}, 32'h0);
    chk("emptypp_data",      {24'h0, recv_data},  32'h5A);
    addr = A_TX; mmio_re = 1'b1;
    tick();
    mmio_re = 1'b0; addr = '0;
    chk("bad_addr_rd", {24'h0, recv_data}, 32'h5A);
    rd(8'h5A, "emptypp_rd");
    chk("emptypp_end", {31'h0, recv_empty}, 32'h1);

    // TX full with simultaneous pop and store: store dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h30 + i);
    tx_ready = 1'b1;
    wr(A_TX, 32'hEE);
    for (int i = 1; i < 8; i++) begin
      chk("txfull_pp_data", {24'h0, tx_data}, 32'h30 + i);
      tick();
    end
    chk("txfull_pp_dropped", {31'h0, tx_valid}, 32'h0);

    // Reset mid-drain
    tx_ready = 1'b0;
    wr(A_TX, 32'h61);
    wr(A_TX, 32'h62);
    wr(A_TX, 32'h63);
    tx_ready = 1'b1;
    tick();
    chk("mid_head", {24'h0, tx_data}, 32'h62);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_data",  {24'h0, tx_data},  32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_valid", {31'h0, tx_valid},   32'h0);
    chk("post_rst_empty", {31'h0, recv_empty}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
